// File: rtl/tl_log_pkg.sv
// Shared types and constants for the TileLink log collector.
// Records are laid out field-for-field like the writer-side outputs.
package tl_log_pkg;

    localparam int STAMP_W = 64;
    localparam int BEAT_W  = 256;

    localparam logic [7:0] TL_CH_A = 8'd0;
    localparam logic [7:0] TL_CH_D = 8'd3;

    typedef struct packed {
        logic [63:0] echo;
        logic [63:0] user;
        logic [63:0] data_3;
        logic [63:0] data_2;
        logic [63:0] data_1;
        logic [63:0] data_0;
        logic [63:0] address;
        logic [63:0] stamp;
        logic [7:0]  sink;
        logic [7:0]  source;
        logic [7:0]  param;
        logic [7:0]  opcode;
        logic [7:0]  channel;
    } tl_log_rec_t;

endpackage

// File: rtl/tl_log_fifo.sv
// Record FIFO: up to two in-order pushes and one pop per cycle.
// The caller guarantees pushes never exceed the free space plus pop.
module tl_log_fifo
    import tl_log_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [1:0]    push_cnt_i,
    input  tl_log_rec_t   rec0_i,
    input  tl_log_rec_t   rec1_i,
    input  logic          pop_i,
    output tl_log_rec_t   head_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] free_o
);

    localparam int PW = $clog2(DEPTH);

    tl_log_rec_t   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer and occupancy next-state; pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q + PW'(push_cnt_i);
        rd_d  = rd_q + PW'(pop_i);
        cnt_d = cnt_q + CW'(push_cnt_i) - CW'(pop_i);
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage writes; first push lands before the second.
    always_ff @(posedge clk_i) begin
        if (push_cnt_i != 2'd0) begin
            mem_q[wr_q] <= rec0_i;
        end
        if (push_cnt_i == 2'd2) begin
            mem_q[wr_q + PW'(1)] <= rec1_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign free_o  = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/tl_log_collector.sv
// Snoops TileLink A/D handshakes into timestamped log records.
// Simultaneous A/D fires are serialised A-first through a small FIFO.
module tl_log_collector
    import tl_log_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SRC_W  = 8,
    parameter int SINK_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              log_en,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [63:0]       a_address,
    input  logic [255:0]      a_data,
    input  logic [63:0]       a_user,
    input  logic [63:0]       a_echo,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [1:0]        d_param,
    input  logic [SRC_W-1:0]  d_source,
    input  logic [SINK_W-1:0] d_sink,
    input  logic [255:0]      d_data,
    input  logic [63:0]       d_user,
    input  logic [63:0]       d_echo,
    output logic              out_en,
    output logic [63:0]       out_echo,
    output logic [63:0]       out_user,
    output logic [63:0]       out_data_0,
    output logic [63:0]       out_data_1,
    output logic [63:0]       out_data_2,
    output logic [63:0]       out_data_3,
    output logic [63:0]       out_address,
    output logic [63:0]       out_stamp,
    output logic [7:0]        out_sink,
    output logic [7:0]        out_source,
    output logic [7:0]        out_param,
    output logic [7:0]        out_opcode,
    output logic [7:0]        out_channel,
    output logic [15:0]       drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [15:0]        drop_q, drop_d;
    logic [16:0]        drop_sum;
    tl_log_rec_t        rec_a, rec_d, rec0, head, shown;
    logic               req_a, req_d, pop;
    logic [1:0]         n_req, n_acc, n_drop;
    logic [CW-1:0]      count, free, space;

    // Build both candidate records from the live channel fields.
    always_comb begin
        rec_a         = '0;
        rec_a.channel = TL_CH_A;
        rec_a.opcode  = {5'd0, a_opcode};
        rec_a.param   = {5'd0, a_param};
        rec_a.source  = 8'(a_source);
        rec_a.address = a_address;
        rec_a.data_0  = a_data[63:0];
        rec_a.data_1  = a_data[127:64];
        rec_a.data_2  = a_data[191:128];
        rec_a.data_3  = a_data[255:192];
        rec_a.user    = a_user;
        rec_a.echo    = a_echo;
        rec_a.stamp   = stamp_q;
        rec_d         = '0;
        rec_d.channel = TL_CH_D;
        rec_d.opcode  = {5'd0, d_opcode};
        rec_d.param   = {6'd0, d_param};
        rec_d.source  = 8'(d_source);
        rec_d.sink    = 8'(d_sink);
        rec_d.data_0  = d_data[63:0];
        rec_d.data_1  = d_data[127:64];
        rec_d.data_2  = d_data[191:128];
        rec_d.data_3  = d_data[255:192];
        rec_d.user    = d_user;
        rec_d.echo    = d_echo;
        rec_d.stamp   = stamp_q;
    end

    assign req_a = log_en & a_valid & a_ready;
    assign req_d = log_en & d_valid & d_ready;
    assign n_req = {1'b0, req_a} + {1'b0, req_d};
    assign pop   = (count != '0);
    assign space = free + {{(CW-1){1'b0}}, pop};
    assign rec0  = req_a ? rec_a : rec_d;

    // Admit as many requests as space allows; A wins the last slot.
    always_comb begin
        n_acc = n_req;
        if (space == '0) begin
            n_acc = 2'd0;
        end else if (space == CW'(1) && n_req == 2'd2) begin
            n_acc = 2'd1;
        end
    end

    assign n_drop   = n_req - n_acc;
    assign drop_sum = {1'b0, drop_q} + {15'd0, n_drop};

    // Next stamp and saturating drop total.
    always_comb begin
        stamp_d = stamp_q + 64'd1;
        drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Stamp counter and drop counter state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stamp_q <= '0;
            drop_q  <= '0;
        end else begin
            stamp_q <= stamp_d;
            drop_q  <= drop_d;
        end
    end

    tl_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_ni     (reset),
        .push_cnt_i (n_acc),
        .rec0_i     (rec0),
        .rec1_i     (rec_d),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .free_o     (free)
    );

    assign shown       = pop ? head : '0;
    assign out_en      = pop;
    assign out_echo    = shown.echo;
    assign out_user    = shown.user;
    assign out_data_0  = shown.data_0;
    assign out_data_1  = shown.data_1;
    assign out_data_2  = shown.data_2;
    assign out_data_3  = shown.data_3;
    assign out_address = shown.address;
    assign out_stamp   = shown.stamp;
    assign out_sink    = shown.sink;
    assign out_source  = shown.source;
    assign out_param   = shown.param;
    assign out_opcode  = shown.opcode;
    assign out_channel = shown.channel;
    assign drop_cnt    = drop_q;

endmodule
